frame_reg_updater: RTL and testbench
====================================

# frame_reg_updater

Frame-synchronous register-file engine for the VGA register display. It holds eight 16-bit registers and updates them once per frame, on the rising edge of the vertical sync signal. Each update is a fixed 8-cycle sequence that performs one register write per clock, with no multi-write blocking assignments. A combinational read port feeds the register-to-pixel renderer directly, and the engine drives an external combinational ALU whose result is written into register 7.

## Interface
- WIDTH, 16, register and ALU data width
- clk  in  1  pixel clock (PLL output); the only clock
- resetn  in  1  asynchronous active-low reset
- vsync  in  1  vertical sync from the sync generator, synchronous to clk
- enable  in  1  when low, vsync edges are ignored (no update, no overrun)
- alu_op1  out  WIDTH  operand 1 to the ALU; always equals reg[1]
- alu_op2  out  WIDTH  operand 2 to the ALU; always equals reg[2]
- alu_result  in  WIDTH  combinational ALU result
- rd_addr  in  3  display read address (driven from vpos[7:5])
- rd_data  out  WIDTH  reg[rd_addr]; combinational, no latency
- busy  out  1  high while an update sequence is running
- done  out  1  one-cycle pulse when a sequence completes
- overrun  out  1  sticky flag; set when a vsync edge arrives while busy
- frame_count  out  16  number of completed update sequences, mod 2^16

## Operation
- Edge detect: vsync_q <= vsync on every clock. A start event occurs when vsync=1 AND vsync_q=0.
- vsync_q resets to 1, so no spurious start is generated when reset is released with vsync high.
- States: IDLE, ALU, INC.
- IDLE: on a start event with enable=1, go to ALU. A start event with enable=0 is ignored.
- ALU (1 cycle): reg[7] <= alu_result, computed from the pre-update reg[1] and reg[2]. Set idx <= 0 and go to INC.
- INC (7 cycles): reg[idx] <= reg[idx] + (idx+1), truncated to WIDTH bits (wrap-around). idx increments each cycle. When idx=6, the state after the write is IDLE.
  - Resulting per-frame increments: reg0 +1, reg1 +2, reg2 +3, reg3 +4, reg4 +5, reg5 +6, reg6 +7.
- On the INC write with idx=6, frame_count is incremented in the same cycle, and done is asserted in the following cycle.
- A start event in any state other than IDLE sets overrun, which is cleared only by reset. The edge is dropped; the sequence is neither restarted nor extended. This includes an edge on the final INC cycle.
- rd_data reflects the live array. A read during an update may return a mix of old and new values; this is acceptable because the sequence runs inside vertical blanking.
- busy = (state != IDLE).

## Timing
- Reset (asynchronous, takes effect immediately without a clock): all eight registers 0, state IDLE, idx 0, busy 0, done 0, overrun 0, frame_count 0, vsync_q 1.
- Reset asserted mid-sequence aborts the sequence. Registers are cleared, not left partially updated.
- Let E be the clock edge at which the start event is sampled. Registered outputs change at the edges below.

| Edge | Effect |
|---|---|
| E | state -> ALU; busy=1 |
| E+1 | reg[7] written |
| E+2 .. E+8 | reg[0] .. reg[6] written, one per edge |
| E+8 | frame_count incremented; state -> IDLE; busy=0 |
| E+9 | done=1 for one cycle (falls at E+10) |

- busy is high for exactly 8 cycles.
- The earliest next start event that is accepted is sampled at E+9.
- alu_op1, alu_op2 and rd_data are combinational from the array. They show new values in the cycle after each write.

## Test plan
- **Reset:** hold resetn=0, then release with vsync=1. Required: rd_data=0 for all 8 addresses, busy=0, done=0, overrun=0, frame_count=0. Hold vsync high for 20 cycles; no update occurs.
- **Single frame** (bench ALU model = add): one vsync rising edge. Required:
  - busy high for exactly 8 cycles; done pulses once at E+9.
  - reg0..reg6 = 1,2,3,4,5,6,7; reg7 = 0; frame_count = 1.
- **Three frames, add ALU.** Required:
  - after frame 2: reg1=4, reg2=6, reg7=5.
  - after frame 3: reg1=6, reg2=9, reg7=10; frame_count=3; overrun=0.
- **Wrap-around:** 9363 frames. Required: reg6 = 65541 mod 65536 = 5, reg0 = 9363, frame_count = 9363.
- **Overrun and enable:**
  - Second vsync rising edge sampled at E+4. Required: one sequence only (reg0=1, frame_count=1), overrun=1.
  - Then pulse vsync with enable=0. Required: no register change, overrun stays 1, frame_count stays 1.
- **Reset mid-sequence:** assert resetn=0 between E+5 and E+6, asynchronously to clk. Required: all rd_data=0 and busy=0 before the next clock edge. After release with vsync held high, no update until a fresh low-to-high vsync transition.

Source files
------------

// File: rtl/frame_reg_updater.sv
// Frame-synchronous register-file engine: eight registers updated once per
// vsync rising edge by a fixed ALU + increment sequence, one write per clock.
//
// state | meaning
// IDLE  | waiting for an enabled vsync rising edge
// ALU   | reg[7] <= alu_result (one cycle)
// INC   | reg[idx] <= reg[idx] + idx + 1, idx = 0..6 (seven cycles)
module frame_reg_updater #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             vsync,
    input  logic             enable,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [2:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic [15:0]      frame_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ALU  = 2'd1,
        INC  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] regs [8];
    logic [2:0]       idx;
    logic             vsync_q;
    logic             start;
    logic             last_write;
    logic             fin_q;
    logic [WIDTH-1:0] inc_val;

    // vsync_q resets high so releasing reset with vsync high is not an edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vsync_q <= 1'b1;
        end else begin
            vsync_q <= vsync;
        end
    end

    assign start = vsync & ~vsync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && enable) state_nxt = ALU;
            ALU:  state_nxt = INC;
            INC:  if (idx == 3'd6) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        last_write = (state == INC) && (idx == 3'd6);
    end

    assign inc_val = WIDTH'(idx) + WIDTH'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                ALU:     regs[7]   <= alu_result;
                INC:     regs[idx] <= regs[idx] + inc_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx <= 3'd0;
        end else if (state == ALU) begin
            idx <= 3'd0;
        end else if (state == INC) begin
            idx <= idx + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_count <= 16'd0;
        end else if (last_write) begin
            frame_count <= frame_count + 16'd1;
        end
    end

    // done trails the final write by one cycle, hence the extra stage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fin_q <= 1'b0;
            done  <= 1'b0;
        end else begin
            fin_q <= last_write;
            done  <= fin_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun <= 1'b0;
        end else if (start && enable && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

    assign alu_op1 = regs[1];
    assign alu_op2 = regs[2];
    assign rd_data = regs[rd_addr];

endmodule

// File: tb/tb_frame_reg_updater.sv
// Directed bench for frame_reg_updater with an adder as the external ALU.
`timescale 1ns/100ps
module tb_frame_reg_updater;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        vsync = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] alu_op1;
    logic [15:0] alu_op2;
    logic [15:0] alu_result;
    logic [2:0]  rd_addr = 3'd0;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [15:0] frame_count;

    int n_tests = 0;
    int n_fail = 0;

    frame_reg_updater #(.WIDTH(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .vsync       (vsync),
        .enable      (enable),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_result  (alu_result),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    assign alu_result = alu_op1 + alu_op2;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rd(input int a, output logic [15:0] d);
        rd_addr = 3'(a);
        #1;
        d = rd_data;
    endtask

    // one accepted frame every 9 clocks, the tightest legal spacing
    task automatic frame();
        @(negedge clk) vsync = 1'b1;
        @(negedge clk) vsync = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        vsync  = 1'b0;
        enable = 1'b1;
        @(negedge clk) resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] d;
        int busy_cnt;
        int done_cnt;
        int done_at;

        // reset, released with vsync high
        #23 resetn = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 8; a++) begin
            rd(a, d);
            check($sformatf("reset_reg%0d", a), 32'(d), 32'd0);
        end
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_fc", 32'(frame_count), 32'd0);
        repeat (20) @(negedge clk);
        rd(0, d);
        check("vsync_high_reg0", 32'(d), 32'd0);
        check("vsync_high_fc", 32'(frame_count), 32'd0);

        // single frame with busy/done timing
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        vsync = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            if (k == 1) vsync = 1'b0;
        end
        check("f1_busy_cycles", 32'(busy_cnt), 32'd8);
        check("f1_done_count", 32'(done_cnt), 32'd1);
        check("f1_done_at", 32'(done_at), 32'd10);
        for (int a = 0; a < 7; a++) begin
            rd(a, d);
            check($sformatf("f1_reg%0d", a), 32'(d), 32'(a + 1));
        end
        rd(7, d);
        check("f1_reg7", 32'(d), 32'd0);
        check("f1_fc", 32'(frame_count), 32'd1);

        frame();
        settle();
        rd(1, d); check("f2_reg1", 32'(d), 32'd4);
        rd(2, d); check("f2_reg2", 32'(d), 32'd6);
        rd(7, d); check("f2_reg7", 32'(d), 32'd5);

        frame();
        settle();
        rd(1, d); check("f3_reg1", 32'(d), 32'd6);
        rd(2, d); check("f3_reg2", 32'(d), 32'd9);
        rd(7, d); check("f3_reg7", 32'(d), 32'd10);
        check("f3_fc", 32'(frame_count), 32'd3);
        check("f3_overrun", 32'(overrun), 32'd0);

        // wrap-around: 9363 * 7 = 65541 -> 5
        do_reset();
        for (int f = 0; f < 9363; f++) frame();
        settle();
        rd(6, d); check("wrap_reg6", 32'(d), 32'd5);
        rd(0, d); check("wrap_reg0", 32'(d), 32'd9363);
        rd(1, d); check("wrap_reg1", 32'(d), 32'd18726);
        check("wrap_fc", 32'(frame_count), 32'd9363);
        check("wrap_overrun", 32'(overrun), 32'd0);

        // second edge sampled at E+4
        do_reset();
        @(negedge clk) vsync = 1'b1;
        @(negedge clk) vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        @(negedge clk) vsync = 1'b0;
        repeat (10) @(negedge clk);
        rd(0, d); check("ovr_reg0", 32'(d), 32'd1);
        rd(6, d); check("ovr_reg6", 32'(d), 32'd7);
        check("ovr_fc", 32'(frame_count), 32'd1);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_busy", 32'(busy), 32'd0);

        enable = 1'b0;
        frame();
        settle();
        enable = 1'b1;
        rd(0, d); check("dis_reg0", 32'(d), 32'd1);
        rd(7, d); check("dis_reg7", 32'(d), 32'd0);
        check("dis_fc", 32'(frame_count), 32'd1);
        check("dis_overrun", 32'(overrun), 32'd1);

        // edge sampled on the final INC cycle (E+8) is an overrun too
        do_reset();
        @(negedge clk) vsync = 1'b1;
        @(negedge clk) vsync = 1'b0;
        repeat (7) @(negedge clk);
        vsync = 1'b1;
        @(negedge clk) vsync = 1'b0;
        repeat (12) @(negedge clk);
        check("last_ovr_fc", 32'(frame_count), 32'd1);
        check("last_ovr_flag", 32'(overrun), 32'd1);
        rd(0, d); check("last_ovr_reg0", 32'(d), 32'd1);

        // asynchronous reset between E+5 and E+6
        do_reset();
        @(negedge clk) vsync = 1'b1;
        @(negedge clk) vsync = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        vsync  = 1'b1;
        resetn = 1'b0;
        #0.2;
        check("midrst_busy", 32'(busy), 32'd0);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #0.2;
            check($sformatf("midrst_reg%0d", a), 32'(rd_data), 32'd0);
        end
        @(negedge clk) resetn = 1'b1;
        repeat (20) @(negedge clk);
        rd(0, d); check("post_rst_reg0", 32'(d), 32'd0);
        check("post_rst_fc", 32'(frame_count), 32'd0);
        vsync = 1'b0;
        frame();
        settle();
        rd(0, d); check("fresh_edge_reg0", 32'(d), 32'd1);
        check("fresh_edge_fc", 32'(frame_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
